// File: rtl/exibe_sequencia_pkg.sv
// rtl/exibe_sequencia_pkg.sv - state codes and default timing for the sequence playback controller
package exibe_sequencia_pkg;

    // State codes double as the db_estado value shown on hexa7seg.
    typedef enum logic [4:0] {
        OCIOSO  = 5'd0,
        LE_MEM  = 5'd1,
        CARREGA = 5'd2,
        ACENDE  = 5'd3,
        APAGA   = 5'd4,
        FIM     = 5'd5,
        PAUSA   = 5'd6
    } estado_t;

    // Default on/off intervals: 0.5 s each at a 1 kHz clock.
    localparam int T_ON_PADRAO  = 500;
    localparam int T_OFF_PADRAO = 500;

endpackage

// File: rtl/exibe_sequencia_uc_if.sv
// rtl/exibe_sequencia_uc_if.sv - control, RAM and LED signals between the main UC and the playback controller
interface exibe_sequencia_uc_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              iniciar;
    logic              abortar;
    logic [ADDR_W-1:0] rodada;
    logic [DATA_W-1:0] mem_dado;
    logic [ADDR_W-1:0] mem_endereco;
    logic [DATA_W-1:0] leds;
    logic              ocupado;
    logic              fim;
    logic [4:0]        db_estado;

    // Main UC and RAM side: issues commands, supplies read data.
    modport master (
        output iniciar, abortar, rodada, mem_dado,
        input  mem_endereco, leds, ocupado, fim, db_estado
    );

    // Playback controller side.
    modport slave (
        input  iniciar, abortar, rodada, mem_dado,
        output mem_endereco, leds, ocupado, fim, db_estado
    );
endinterface

// File: rtl/exibe_sequencia_uc_contador_intervalo.sv
// rtl/exibe_sequencia_uc_contador_intervalo.sv - interval timer with loadable terminal count
module contador_intervalo #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera_i,
    input  logic         conta_i,
    input  logic [W-1:0] terminal_i,
    output logic         fim_intervalo_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear has priority; the count parks on the terminal value instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (zera_i) begin
            cnt_d = '0;
        end else if (conta_i && !fim_intervalo_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim_intervalo_o = (cnt_q == terminal_i);

endmodule

// File: rtl/exibe_sequencia_uc.sv
// rtl/exibe_sequencia_uc.sv - plays the stored sequence on the LEDs; SEQ_PAUSA_INICIAL_EN adds a dark lead-in
module exibe_sequencia_uc
    import exibe_sequencia_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = T_ON_PADRAO,
    parameter int T_OFF  = T_OFF_PADRAO
) (
    input  logic                 clock,
    input  logic                 reset,
    exibe_sequencia_uc_if.slave  bus
);
    localparam int TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW   = $clog2(TMAX + 1);

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [DATA_W-1:0] leds_q, leds_d;
    logic [ADDR_W-1:0] rodada_q, rodada_d;
    logic              zera;
    logic              conta;
    logic [TW-1:0]     terminal;
    logic              fim_int;

    contador_intervalo #(.W(TW)) u_contador (
        .clock           (clock),
        .reset           (reset),
        .zera_i          (zera),
        .conta_i         (conta),
        .terminal_i      (terminal),
        .fim_intervalo_o (fim_int)
    );

    // Next state, address/LED updates and timer control. The timer is held
    // clear outside timed states and cleared on the terminal cycle, so every
    // timed state starts counting from zero.
    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        leds_d     = leds_q;
        rodada_d   = rodada_q;
        zera       = 1'b1;
        conta      = 1'b0;
        terminal   = TW'(T_OFF - 1);

        if (estado_q != OCIOSO && bus.abortar) begin
            estado_d   = OCIOSO;
            endereco_d = '0;
            leds_d     = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    leds_d = '0;
                    if (bus.iniciar && !bus.abortar) begin
                        rodada_d   = bus.rodada;
                        endereco_d = '0;
`ifdef SEQ_PAUSA_INICIAL_EN
                        estado_d   = PAUSA;
`else
                        estado_d   = LE_MEM;
`endif
                    end
                end
`ifdef SEQ_PAUSA_INICIAL_EN
                PAUSA: begin
                    leds_d = '0;
                    conta  = 1'b1;
                    zera   = fim_int;
                    if (fim_int) begin
                        estado_d = LE_MEM;
                    end
                end
`endif
                LE_MEM: begin
                    estado_d = CARREGA;
                end
                CARREGA: begin
                    leds_d   = bus.mem_dado;
                    estado_d = ACENDE;
                end
                ACENDE: begin
                    terminal = TW'(T_ON - 1);
                    conta    = 1'b1;
                    zera     = fim_int;
                    if (fim_int) begin
                        leds_d   = '0;
                        estado_d = APAGA;
                    end
                end
                APAGA: begin
                    leds_d = '0;
                    conta  = 1'b1;
                    zera   = fim_int;
                    if (fim_int) begin
                        if (endereco_q == rodada_q) begin
                            estado_d = FIM;
                        end else begin
                            endereco_d = endereco_q + ADDR_W'(1);
                            estado_d   = LE_MEM;
                        end
                    end
                end
                FIM: begin
                    leds_d   = '0;
                    estado_d = OCIOSO;
                end
                default: begin
                    leds_d   = '0;
                    estado_d = OCIOSO;
                end
            endcase
        end
    end

    // State, address, LED and captured-round registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= '0;
            leds_q     <= '0;
            rodada_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            leds_q     <= leds_d;
            rodada_q   <= rodada_d;
        end
    end

    assign bus.mem_endereco = endereco_q;
    assign bus.leds         = leds_q;
    assign bus.ocupado      = (estado_q != OCIOSO);
    assign bus.fim          = (estado_q == FIM);
    assign bus.db_estado    = estado_q;

endmodule

// File: tb/tb_exibe_sequencia_uc.sv
// tb/tb_exibe_sequencia_uc.sv - bench for exibe_sequencia_uc; honours SEQ_PAUSA_INICIAL_EN
module tb_exibe_sequencia_uc;
    localparam int T_ON  = 4;
    localparam int T_OFF = 2;
    localparam int P     = 2 + T_ON + T_OFF;
`ifdef SEQ_PAUSA_INICIAL_EN
    localparam int LEAD  = T_OFF;
`else
    localparam int LEAD  = 0;
`endif

    typedef struct packed {
        logic [4:0] db;
        logic [3:0] leds;
        logic [3:0] addr;
        logic       ocup;
        logic       fim;
    } obs_t;

    typedef struct {
        int r;
        int abort_c;
        bit noise;
        int exp_fim_edge;
        int exp_fims;
        int exp_bursts;
    } vec_t;

    logic clock;
    logic reset;
    logic [3:0] ram [16];
    int checks;
    int errors;

    exibe_sequencia_uc_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    exibe_sequencia_uc #(.ADDR_W(4), .DATA_W(4), .T_ON(T_ON), .T_OFF(T_OFF)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read RAM: data appears one cycle after the address.
    always @(posedge clock) bus.mem_dado <= ram[bus.mem_endereco];

    // Expected outputs c cycles after the start edge, derived from the element period.
    function automatic obs_t model(int c, int r, int abort_c);
        obs_t o;
        int cc, e, k;
        o = '0;
        if (abort_c >= 0 && c > abort_c) return o;
        if (c < LEAD) begin
            o.db = 5'd6;
            o.ocup = 1'b1;
            return o;
        end
        cc = c - LEAD;
        if (cc < P * (r + 1)) begin
            e = cc / P;
            k = cc % P;
            o.addr = 4'(e);
            o.ocup = 1'b1;
            if (k == 0) o.db = 5'd1;
            else if (k == 1) o.db = 5'd2;
            else if (k < 2 + T_ON) begin
                o.db = 5'd3;
                o.leds = ram[e];
            end else o.db = 5'd4;
        end else if (cc == P * (r + 1)) begin
            o.db = 5'd5;
            o.addr = 4'(r);
            o.ocup = 1'b1;
            o.fim = 1'b1;
        end else begin
            o.addr = 4'(r);
        end
        return o;
    endfunction

    function automatic obs_t observe();
        return {bus.db_estado, bus.leds, bus.mem_endereco, bus.ocupado, bus.fim};
    endfunction

    task automatic chk_obs(string name, obs_t exp);
        obs_t act;
        act = observe();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got db=%0d leds=%b addr=%0d ocup=%b fim=%b, expected db=%0d leds=%b addr=%0d ocup=%b fim=%b",
                     name, act.db, act.leds, act.addr, act.ocup, act.fim,
                     exp.db, exp.leds, exp.addr, exp.ocup, exp.fim);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One playback from a start pulse, checked every cycle against the model.
    task automatic run(input int r, input int abort_c, input bit noise_fixed, input bit noise_rand,
                       output int fim_edge, output int fims, output int bursts);
        int endc, last;
        logic [3:0] prev;
        endc = LEAD + P * (r + 1);
        last = (abort_c >= 0 && abort_c < endc) ? abort_c + 3 : endc + 3;
        fim_edge = 0;
        fims = 0;
        bursts = 0;
        prev = '0;
        @(negedge clock);
        bus.rodada = 4'(r);
        bus.iniciar = 1'b1;
        for (int c = 0; c <= last; c++) begin
            @(negedge clock);
            bus.iniciar = 1'b0;
            bus.abortar = 1'b0;
            if (noise_fixed && c >= 5 && c <= 7) begin
                bus.iniciar = 1'b1;
                bus.rodada = 4'd0;
            end
            if (noise_rand && c <= endc && (abort_c < 0 || c < abort_c)) begin
                bus.iniciar = 1'($urandom_range(0, 1));
                bus.rodada = 4'($urandom);
            end
            if (c == abort_c) bus.abortar = 1'b1;
            chk_obs($sformatf("r%0d_cycle%0d", r, c), model(c, r, abort_c));
            if (bus.fim) begin
                fims++;
                if (fim_edge == 0) fim_edge = c + 1;
            end
            if (bus.leds != 4'd0 && prev == 4'd0) bursts++;
            prev = bus.leds;
        end
        bus.iniciar = 1'b0;
        bus.abortar = 1'b0;
    endtask

    initial begin
        vec_t vecs [4];
        int fe, nf, nb, r, ab, endc;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) ram[i] = 4'b1000;
        ram[0] = 4'b0001;
        ram[1] = 4'b0010;
        ram[2] = 4'b0100;
        bus.iniciar = 1'b0;
        bus.abortar = 1'b0;
        bus.rodada = 4'd0;

        vecs[0] = '{r: 2, abort_c: -1,        noise: 1'b0, exp_fim_edge: 25 + LEAD, exp_fims: 1, exp_bursts: 3};
        vecs[1] = '{r: 0, abort_c: -1,        noise: 1'b0, exp_fim_edge: 9 + LEAD,  exp_fims: 1, exp_bursts: 1};
        vecs[2] = '{r: 2, abort_c: 11 + LEAD, noise: 1'b0, exp_fim_edge: 0,         exp_fims: 0, exp_bursts: 2};
        vecs[3] = '{r: 2, abort_c: -1,        noise: 1'b1, exp_fim_edge: 25 + LEAD, exp_fims: 1, exp_bursts: 3};

        // Reset state with the clock running.
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk_obs("reset_state", '0);

        // abortar and iniciar together while idle: abortar wins.
        bus.iniciar = 1'b1;
        bus.abortar = 1'b1;
        repeat (3) @(negedge clock);
        chk_obs("abort_beats_start", '0);
        bus.iniciar = 1'b0;
        bus.abortar = 1'b0;
        @(negedge clock);

        // Directed playbacks.
        for (int v = 0; v < 4; v++) begin
            run(vecs[v].r, vecs[v].abort_c, vecs[v].noise, 1'b0, fe, nf, nb);
            chk_int($sformatf("vec%0d_fim_edge", v), fe, vecs[v].exp_fim_edge);
            chk_int($sformatf("vec%0d_fim_count", v), nf, vecs[v].exp_fims);
            chk_int($sformatf("vec%0d_bursts", v), nb, vecs[v].exp_bursts);
        end

        // Asynchronous reset in the first APAGA.
        @(negedge clock);
        bus.rodada = 4'd2;
        bus.iniciar = 1'b1;
        for (int c = 0; c <= LEAD + 2 + T_ON; c++) begin
            @(negedge clock);
            bus.iniciar = 1'b0;
        end
        chk_obs("before_async_reset", model(LEAD + 2 + T_ON, 2, -1));
        #2;
        reset = 1'b0;
        #1;
        chk_obs("async_reset_immediate", '0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk_obs("after_async_reset_idle", '0);

        // Randomized playbacks with random RAM contents, inputs and aborts.
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 16; i++) ram[i] = 4'(1 << $urandom_range(0, 3));
            r = (n == 0) ? 15 : $urandom_range(0, 15);
            endc = LEAD + P * (r + 1);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, endc) : -1;
            run(r, ab, 1'b0, 1'b1, fe, nf, nb);
            if (ab < 0 || ab >= endc) begin
                chk_int($sformatf("rand%0d_fim_edge", n), fe, endc + 1);
                chk_int($sformatf("rand%0d_fim_count", n), nf, 1);
            end else begin
                chk_int($sformatf("rand%0d_no_fim", n), nf, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exibe_sequencia_uc.md
Name: exibe_sequencia_uc

Overview:
- Controller that plays the stored game sequence on the LEDs, from address 0 up to the current round, before the player's turn.
- Drives the RAM address and latches the RAM data into a LED register.
- Times each LED on/off interval with an internal timer.
- Sits beside exp7_unidade_controle. The main UC starts it with `iniciar` and waits for `fim`; it then owns the LEDs and RAM address only while `ocupado`=1.

Parameters:
- ADDR_W, 4, width of RAM address and `rodada`.
- DATA_W, 4, width of RAM word and `leds` (one-hot button code).
- T_ON, 500, cycles each LED stays lit (0.5 s at 1 kHz). Must be ≥1.
- T_OFF, 500, cycles of dark gap after each LED. Must be ≥1.

Ports:
- clock, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous, active-low; 0 forces reset state immediately.
- iniciar, in, 1, start pulse; sampled only in OCIOSO.
- abortar, in, 1, cancels playback from any busy state.
- rodada, in, ADDR_W, last address to show (inclusive); captured on start.
- mem_dado, in, DATA_W, RAM read data; valid 1 cycle after `mem_endereco` is stable.
- mem_endereco, out, ADDR_W, registered RAM address.
- leds, out, DATA_W, registered LED drive.
- ocupado, out, 1, high in every state except OCIOSO.
- fim, out, 1, single-cycle completion pulse.
- db_estado, out, 5, state code for hexa7seg.

Behaviour:
- Reset (reset=0, asynchronous) applies this state immediately, mid-operation included:
  - state=OCIOSO
  - mem_endereco=0, leds=0, fim=0, ocupado=0
  - timer=0, captured rodada=0
- OCIOSO (code 0):
  - leds=0.
  - iniciar=1 → capture `rodada`, mem_endereco←0, timer←0, go to LE_MEM.
- LE_MEM (1): exactly 1 cycle; address stable while the RAM samples it. Next state is CARREGA.
- CARREGA (2): exactly 1 cycle; leds←mem_dado at the closing edge. Next state is ACENDE.
- ACENDE (3):
  - leds held for T_ON cycles; timer counts 0..T_ON-1.
  - On terminal count: leds←0, timer←0, go to APAGA.
- APAGA (4): leds=0 for T_OFF cycles. On terminal count:
  - if mem_endereco == captured rodada → FIM;
  - else mem_endereco←mem_endereco+1 and go to LE_MEM.
- FIM (5): fim=1 for exactly 1 cycle, ocupado=1, then OCIOSO.
- Period per element: 2+T_ON+T_OFF cycles. rodada=N shows N+1 elements.
- iniciar while busy is ignored (no restart). Changes to `rodada` input while busy are ignored.
- abortar=1 in any state other than OCIOSO:
  - next cycle is OCIOSO with leds=0, mem_endereco=0;
  - no fim pulse.
- abortar and iniciar together in OCIOSO: abortar wins, stay OCIOSO.
- rodada = 2^ADDR_W−1: last element shown, no address wrap; address never exceeds rodada.
- Timer width $clog2(max(T_ON,T_OFF)+1). Timer wraps never; it is cleared on each state entry.
- Unused state codes → OCIOSO.

Optional Feature:
- Macro: SEQ_PAUSA_INICIAL_EN.
- Defined: adds state PAUSA (code 6) between OCIOSO and the first LE_MEM only. leds=0 there for T_OFF cycles, giving the player a dark lead-in. Total playback grows by T_OFF cycles.
- Undefined: OCIOSO goes directly to LE_MEM; code 6 is unused.

Decomposition:
- Shared package exibe_sequencia_pkg holds:
  - state encoding constants (OCIOSO..PAUSA, 5-bit, matching db_estado);
  - default T_ON/T_OFF constants.
- One sub-module is natural: contador_intervalo, a loadable-terminal-count timer with zera/conta inputs and a `fim_intervalo` output. The FSM and address/LED registers stay in the top.

Test Plan (T_ON=4, T_OFF=2, RAM[0]=0001, RAM[1]=0010, RAM[2]=0100):
- Reset state: reset=0 then 1, clock idle → leds=0, mem_endereco=0, ocupado=0, fim=0, db_estado=0.
- Full playback: iniciar pulse with rodada=2 →
  - leds waveform: 0001 for 4 cycles, 0 for 4, 0010 for 4, 0 for 4, 0100 for 4, then 0;
  - fim pulses once, 25 cycles after the iniciar edge;
  - ocupado low the following cycle.
- Single element, rodada=0: iniciar → exactly one 0001 burst of 4 cycles; fim 9 cycles after start; mem_endereco never leaves 0.
- Abort: abortar=1 during the second ACENDE → next cycle db_estado=0, leds=0, mem_endereco=0; no fim pulse.
- Ignored inputs: iniciar repeated and rodada changed to 0 mid-playback → sequence completes all 3 elements unaltered; exactly one fim pulse.
- Reset mid-operation: reset=0 asynchronously during APAGA → outputs go to reset values immediately, without waiting for a clock edge. With SEQ_PAUSA_INICIAL_EN defined, fim moves to cycle 27.
